// File: rtl/paddle_controller_if.sv
// Signal bundle between the paddle controller and its neighbours.
//   frame_tick  : one-cycle pulse per video frame (buttons sampled only here)
//   up_button   : debounced up level
//   down_button : debounced down level
//   recenter    : one-cycle pulse returning the paddle to its start state
//   paddle_y    : top edge of the paddle
//   speed       : current speed in pixels per frame, 0 when idle
//   moving_up   : paddle is in an upward move
//   moving_down : paddle is in a downward move
//   at_top      : paddle_y is 0
//   at_bottom   : paddle_y is at the lowest legal position
// master drives frame_tick/buttons/recenter; slave is the controller.
interface paddle_controller_if #(
  parameter int unsigned Y_WIDTH = 10
);
  logic               frame_tick;
  logic               up_button;
  logic               down_button;
  logic               recenter;
  logic [Y_WIDTH-1:0] paddle_y;
  logic [3:0]         speed;
  logic               moving_up;
  logic               moving_down;
  logic               at_top;
  logic               at_bottom;

  modport master (
    output frame_tick, up_button, down_button, recenter,
    input  paddle_y, speed, moving_up, moving_down, at_top, at_bottom
  );

  modport slave (
    input  frame_tick, up_button, down_button, recenter,
    output paddle_y, speed, moving_up, moving_down, at_top, at_bottom
  );
endinterface

// File: rtl/paddle_controller.sv
// Turns debounced up/down button levels into a paddle vertical position, updated once
// per frame. Speed ramps while a direction is held; the position is clamped to the
// playfield.
//   clock : system clock, all state changes on its rising edge
//   reset : synchronous, active-high
//   bus   : paddle_controller_if.slave (tick, buttons, recenter in; position/status out)
module paddle_controller #(
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned PADDLE_HEIGHT = 80,
  parameter int unsigned INIT_Y        = 200,
  parameter int unsigned BASE_SPEED    = 2,
  parameter int unsigned MAX_SPEED     = 8,
  parameter int unsigned ACCEL_FRAMES  = 4,
  parameter int unsigned Y_WIDTH       = 10
) (
  input logic               clock,
  input logic               reset,
  paddle_controller_if.slave bus
);

  localparam int unsigned AccW = (ACCEL_FRAMES > 8) ? $clog2(ACCEL_FRAMES) : 3;

  localparam logic [Y_WIDTH:0]   YMax    = (Y_WIDTH+1)'(SCREEN_HEIGHT - PADDLE_HEIGHT);
  localparam logic [Y_WIDTH-1:0] InitY   = Y_WIDTH'(INIT_Y);
  localparam logic [3:0]         BaseSpd = 4'(BASE_SPEED);
  localparam logic [3:0]         MaxSpd  = 4'(MAX_SPEED);
  localparam logic [AccW-1:0]    AccLast = AccW'(ACCEL_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDown} state_e;

  state_e             state_q, state_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic [3:0]         speed_q, speed_d;
  logic [AccW-1:0]    acc_q, acc_d;

  state_e           req;
  logic [3:0]       step;
  logic [Y_WIDTH:0] y_ext;
  logic [Y_WIDTH:0] step_ext;
  logic [Y_WIDTH:0] sum;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      y_q     <= InitY;
      speed_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      speed_q <= speed_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    speed_d  = speed_q;
    acc_d    = acc_q;
    req      = StIdle;
    step     = '0;
    y_ext    = {1'b0, y_q};
    step_ext = '0;
    sum      = '0;

    if (bus.recenter) begin
      // Recenter wins over a coincident tick; the tick is dropped.
      state_d = StIdle;
      y_d     = InitY;
      speed_d = '0;
      acc_d   = '0;
    end else if (bus.frame_tick) begin
      if (bus.up_button && !bus.down_button) begin
        req = StMoveUp;
      end else if (bus.down_button && !bus.up_button) begin
        req = StMoveDown;
      end

      if (req == StIdle) begin
        state_d = StIdle;
        speed_d = '0;
        acc_d   = '0;
      end else begin
        if (req != state_q) begin
          // New move or reversal: restart the ramp and move at base speed now.
          state_d = req;
          speed_d = BaseSpd;
          acc_d   = '0;
          step    = BaseSpd;
        end else begin
          // Continuing: move by the pre-update speed, then advance the ramp.
          step = speed_q;
          if (acc_q == AccLast) begin
            acc_d   = '0;
            speed_d = (speed_q >= MaxSpd) ? MaxSpd : speed_q + 4'd1;
          end else begin
            acc_d = acc_q + 1'b1;
          end
        end

        step_ext = (Y_WIDTH+1)'(step);
        sum      = y_ext + step_ext;
        if (req == StMoveUp) begin
          y_d = (y_ext < step_ext) ? '0 : y_q - step_ext[Y_WIDTH-1:0];
        end else begin
          y_d = (sum > YMax) ? YMax[Y_WIDTH-1:0] : sum[Y_WIDTH-1:0];
        end
      end
    end
  end

  assign bus.paddle_y    = y_q;
  assign bus.speed       = speed_q;
  assign bus.moving_up   = (state_q == StMoveUp);
  assign bus.moving_down = (state_q == StMoveDown);
  assign bus.at_top      = (y_q == '0);
  assign bus.at_bottom   = ({1'b0, y_q} == YMax);

endmodule

// File: tb/tb_paddle_controller.sv
// Randomized plus directed bench for paddle_controller against a frame-level model.
module tb_paddle_controller;

  localparam int YMAX  = 400;
  localparam int INITY = 200;
  localparam int BASE  = 2;
  localparam int MAXS  = 8;
  localparam int ACCF  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  paddle_controller_if #(.Y_WIDTH(10)) bus ();

  paddle_controller #(
    .SCREEN_HEIGHT(480),
    .PADDLE_HEIGHT(80),
    .INIT_Y(200),
    .BASE_SPEED(2),
    .MAX_SPEED(8),
    .ACCEL_FRAMES(4),
    .Y_WIDTH(10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Model: direction 0 none, 1 up, 2 down.
  int m_dir, m_y, m_spd, m_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dir = 0;
    m_y   = INITY;
    m_spd = 0;
    m_acc = 0;
  endtask

  task automatic model_tick(input bit up, input bit dn);
    int req, stp;
    req = (up && !dn) ? 1 : ((dn && !up) ? 2 : 0);
    if (req == 0) begin
      m_dir = 0;
      m_spd = 0;
      m_acc = 0;
    end else begin
      if (req != m_dir) begin
        m_dir = req;
        stp   = BASE;
        m_spd = BASE;
        m_acc = 0;
      end else begin
        stp   = m_spd;
        m_acc = m_acc + 1;
        if (m_acc == ACCF) begin
          m_acc = 0;
          m_spd = (m_spd + 1 > MAXS) ? MAXS : m_spd + 1;
        end
      end
      if (req == 1) m_y = (m_y - stp < 0) ? 0 : m_y - stp;
      else          m_y = (m_y + stp > YMAX) ? YMAX : m_y + stp;
    end
  endtask

  // One clock: drive inputs, advance model with reset > recenter > tick, check #1 after edge.
  task automatic cyc(input bit rst, input bit rc, input bit tk, input bit up, input bit dn);
    reset           = rst;
    bus.recenter    = rc;
    bus.frame_tick  = tk;
    bus.up_button   = up;
    bus.down_button = dn;
    @(posedge clock);
    if (rst)     model_reset();
    else if (rc) model_reset();
    else if (tk) model_tick(up, dn);
    #1;
    check("paddle_y",    32'(bus.paddle_y),    32'(m_y));
    check("speed",       32'(bus.speed),       32'(m_spd));
    check("moving_up",   32'(bus.moving_up),   32'(m_dir == 1));
    check("moving_down", 32'(bus.moving_down), 32'(m_dir == 2));
    check("at_top",      32'(bus.at_top),      32'(m_y == 0));
    check("at_bottom",   32'(bus.at_bottom),   32'(m_y == YMAX));
  endtask

  initial begin
    bit hu, hd;
    bit [9:0] exp_up [6];
    bit [3:0] exp_sp [6];
    exp_up = '{10'd198, 10'd196, 10'd194, 10'd192, 10'd190, 10'd187};
    exp_sp = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3};
    model_reset();
    bus.recenter = 0; bus.frame_tick = 0; bus.up_button = 0; bus.down_button = 0;

    // Reset, then idle ticks.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    check("idle_y", 32'(bus.paddle_y), 32'd200);

    // Up held 6 ticks, with gap cycles between ticks.
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 1, 0);
      check("up_seq_y", 32'(bus.paddle_y), 32'(exp_up[i]));
      check("up_seq_spd", 32'(bus.speed), 32'(exp_sp[i]));
      cyc(0, 0, 0, 0, 1);
    end

    // Down until clamped at the bottom.
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 60; i++) cyc(0, 0, 1, 0, 1);
    check("bottom_y", 32'(bus.paddle_y), 32'd400);
    check("bottom_flag", 32'(bus.at_bottom), 32'd1);
    check("bottom_spd", 32'(bus.speed), 32'd8);

    // Up to 192, reverse, then both buttons.
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 1);
    check("rev_y", 32'(bus.paddle_y), 32'd194);
    check("rev_spd", 32'(bus.speed), 32'd2);
    check("rev_down", 32'(bus.moving_down), 32'd1);
    cyc(0, 0, 1, 1, 1);
    check("both_y", 32'(bus.paddle_y), 32'd194);
    check("both_spd", 32'(bus.speed), 32'd0);

    // Up to speed 5, recenter with coincident tick, then one up tick.
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 13; i++) cyc(0, 0, 1, 1, 0);
    check("spd5", 32'(bus.speed), 32'd5);
    cyc(0, 1, 1, 1, 0);
    check("rc_y", 32'(bus.paddle_y), 32'd200);
    check("rc_spd", 32'(bus.speed), 32'd0);
    cyc(0, 0, 1, 1, 0);
    check("rc_next_y", 32'(bus.paddle_y), 32'd198);

    // Button toggles between ticks, then reset mid-move at speed 7.
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, i[0], ~i[0]);
    check("toggle_y", 32'(bus.paddle_y), 32'd198);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 21; i++) cyc(0, 0, 1, 1, 0);
    check("spd7", 32'(bus.speed), 32'd7);
    check("spd7_y", 32'(bus.paddle_y), 32'd118);
    cyc(1, 0, 1, 1, 0);
    check("rst_y", 32'(bus.paddle_y), 32'd200);
    check("rst_spd", 32'(bus.speed), 32'd0);

    // Randomized phase: buttons held for random stretches so walls and max speed are hit.
    hu = 0; hd = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) hu = ~hu;
      if ($urandom_range(0, 15) == 0) hd = ~hd;
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 63) == 0),
          ($urandom_range(0, 2) != 0), hu, hd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/paddle_controller.md
# paddle_controller

Converts the debounced up/down button levels for one player into a paddle vertical position. It sits directly downstream of the per-button debouncers and upstream of the renderer and collision logic. Position changes once per video frame. Speed ramps while a direction is held, and the paddle is clamped to the playfield.

## Interface
Parameters:
- SCREEN_HEIGHT, 480: playfield height in pixels.
- PADDLE_HEIGHT, 80: paddle height in pixels; Y_MAX = SCREEN_HEIGHT - PADDLE_HEIGHT (400).
- INIT_Y, 200: position after reset or recenter.
- BASE_SPEED, 2: pixels per frame on the first frame of a move.
- MAX_SPEED, 8: speed ceiling, in pixels per frame.
- ACCEL_FRAMES, 4: number of continued-move frames per +1 speed step.
- Y_WIDTH, 10: width of the position bus.

Ports (one clock; reset is synchronous and active-high):
- clock, input, 1: system clock; all state changes on its rising edge.
- reset, input, 1: synchronous, active-high.
- frame_tick, input, 1: one-cycle pulse per frame; the only cycle where buttons are sampled.
- up_button, input, 1: debounced level.
- down_button, input, 1: debounced level.
- recenter, input, 1: one-cycle pulse, for example after a point is scored.
- paddle_y, output, Y_WIDTH: top edge of the paddle, range 0..Y_MAX.
- speed, output, 4: current speed in pixels per frame; 0 when idle.
- moving_up, output, 1: state is MOVE_UP.
- moving_down, output, 1: state is MOVE_DOWN.
- at_top, output, 1: combinational, paddle_y == 0.
- at_bottom, output, 1: combinational, paddle_y == Y_MAX.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN. There is an internal accel_count of at least 3 bits.
- Reset values:
  - state = IDLE, paddle_y = INIT_Y, speed = 0, accel_count = 0.
  - moving_up = 0, moving_down = 0.
  - at_top and at_bottom follow paddle_y, so both are 0 after reset.
- Priority order: reset, then recenter, then frame_tick.
- recenter gives the same result as reset, except it is not a reset. When recenter and frame_tick coincide, the tick is discarded.
- Requested direction at a frame_tick:
  - UP when up_button=1 and down_button=0.
  - DOWN when down_button=1 and up_button=0.
  - NONE otherwise; both buttons pressed counts as NONE.
- Tick with NONE: state becomes IDLE, speed becomes 0, accel_count becomes 0, paddle_y is held.
- Tick with a direction that differs from the current state (entering a move, including a reversal):
  - state is set to the new direction, speed becomes BASE_SPEED, accel_count becomes 0.
  - The paddle moves by BASE_SPEED on this same tick.
- Tick with the same direction as the current state (continuing a move):
  - The paddle moves by the current (pre-update) speed.
  - If accel_count == ACCEL_FRAMES-1: accel_count becomes 0 and speed becomes min(speed+1, MAX_SPEED).
  - Otherwise accel_count increments.
- Moving up: if paddle_y < step, paddle_y becomes 0; otherwise paddle_y - step. No unsigned underflow is allowed.
- Moving down: if paddle_y + step > Y_MAX, paddle_y becomes Y_MAX; otherwise paddle_y + step. Compute the sum at Y_WIDTH+1 bits.
- Hitting a wall clamps the position only. State, speed and the acceleration ramp continue while the button is held.
- Button changes between ticks have no effect; only the level present on the tick cycle matters.

## Timing
- All outputs change in the cycle after the edge that samples frame_tick, recenter or reset.
- Latency from tick to new paddle_y is exactly 1 clock.
- Between ticks all registered outputs are held.
- frame_tick held high for N consecutive cycles is treated as N ticks; no edge detection is performed.
- at_top and at_bottom have zero latency relative to paddle_y.
- The block has no handshake and never stalls; it accepts every tick.

## Test plan
- Reset, then 3 ticks with no buttons -> paddle_y=200, speed=0, moving_up=0, moving_down=0, at_top=0, at_bottom=0 throughout.
- up held for 6 ticks -> paddle_y sequence 198, 196, 194, 192, 190, 187; speed sequence 2, 2, 2, 2, 3, 3; moving_up=1.
- Hold down from 200 until clamped -> paddle_y reaches 400 exactly, at_bottom=1, never exceeds 400; speed keeps ramping to 8 and holds there.
- up held to 192, then down on the next tick -> paddle_y=194, speed=2, moving_down=1. Then both buttons on a tick -> state IDLE, speed=0, paddle_y stays 194.
- recenter coinciding with frame_tick while moving up at speed 5 -> paddle_y=200, speed=0, state IDLE. On the next tick with up held -> paddle_y=198.
- Buttons toggle only between ticks -> no movement; reset asserted mid-move at speed 7 near the top -> next cycle paddle_y=200, speed=0.
